// File: rtl/dcache_arb_pkg.sv
// rtl/dcache_arb_pkg.sv - shared types and constants for the dcache port arbiter
package dcache_arb_pkg;

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_e;

  typedef struct packed {
    lane_e lane;
    logic  drop;
  } tag_entry_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/dcache_port_arbiter_if.sv
// rtl/dcache_port_arbiter_if.sv - lane request/response and dcache port bundle
interface dcache_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              req0_valid;
  logic              req0_op;
  logic [ADDR_W-1:0] req0_addr;
  logic              req0_uncached;
  logic [STRB_W-1:0] req0_wstrb;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;

  logic              req1_valid;
  logic              req1_op;
  logic [ADDR_W-1:0] req1_addr;
  logic              req1_uncached;
  logic [STRB_W-1:0] req1_wstrb;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;

  logic              resp0_valid;
  logic [DATA_W-1:0] resp0_rdata;
  logic              resp1_valid;
  logic [DATA_W-1:0] resp1_rdata;

  logic              dc_valid;
  logic              dc_ready;
  logic              dc_op;
  logic [ADDR_W-1:0] dc_addr;
  logic              dc_uncached;
  logic [STRB_W-1:0] dc_awstrb;
  logic [DATA_W-1:0] dc_wdata;
  logic              dc_rvalid;
  logic [DATA_W-1:0] dc_rdata;

  // Arbiter side: takes lane requests and dcache responses, drives the dcache port.
  modport slave (
    input  req0_valid, req0_op, req0_addr, req0_uncached, req0_wstrb, req0_wdata,
    input  req1_valid, req1_op, req1_addr, req1_uncached, req1_wstrb, req1_wdata,
    output req0_ready, req1_ready,
    output resp0_valid, resp0_rdata, resp1_valid, resp1_rdata,
    output dc_valid, dc_op, dc_addr, dc_uncached, dc_awstrb, dc_wdata,
    input  dc_ready, dc_rvalid, dc_rdata
  );

  // Pipeline/dcache side.
  modport master (
    output req0_valid, req0_op, req0_addr, req0_uncached, req0_wstrb, req0_wdata,
    output req1_valid, req1_op, req1_addr, req1_uncached, req1_wstrb, req1_wdata,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp0_rdata, resp1_valid, resp1_rdata,
    input  dc_valid, dc_op, dc_addr, dc_uncached, dc_awstrb, dc_wdata,
    output dc_ready, dc_rvalid, dc_rdata
  );

endinterface

// File: rtl/dcache_arb_tag_fifo.sv
// rtl/dcache_arb_tag_fifo.sv - in-order tag FIFO of outstanding reads with flush marking
module dcache_arb_tag_fifo
  import dcache_arb_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  tag_entry_t       push_data,
  input  logic             pop,
  input  logic             flush_mark,
  output tag_entry_t       head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  tag_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  // No bypass: a full FIFO refuses a push even when it pops in the same cycle.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointers and occupancy.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

  // Entry storage; flush marks every slot so in-flight responses are discarded.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '{lane: LANE0, drop: 1'b0};
    end else begin
      if (flush_mark) begin
        for (int i = 0; i < DEPTH; i++) mem[i].drop <= 1'b1;
      end
      if (push_ok) mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// rtl/dcache_port_arbiter.sv - fixed-priority two-lane dcache port arbiter (optional DCACHE_ARB_PERF_EN counters)
module dcache_port_arbiter
  import dcache_arb_pkg::*;
#(
  parameter int OUTSTANDING = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 flush,
  output logic                 proto_err,
`ifdef DCACHE_ARB_PERF_EN
  output logic [31:0]          perf_conflict,
  output logic [31:0]          perf_blocked,
`endif
  dcache_port_arbiter_if.slave bus
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(OUTSTANDING + 1);

  lane_e            sel;
  logic             any_valid;
  logic             cand_op;
  logic             blocked;
  logic             accept;
  logic             push;
  logic             pop;
  logic             resp_ok;
  tag_entry_t       head;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;

  // Grant: lane 0 is the older instruction and always wins.
  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
    sel       = bus.req0_valid ? LANE0 : LANE1;
    cand_op   = (sel == LANE0) ? bus.req0_op : bus.req1_op;
    blocked   = (cand_op == OP_READ) && full;
    accept    = bus.dc_valid & bus.dc_ready;
    push      = accept & (cand_op == OP_READ);
    pop       = bus.dc_rvalid & ~empty;
    resp_ok   = aresetn & pop & ~head.drop & ~flush;
  end

  // Request forwarding; fields are zeroed when no lane is requesting.
  always_comb begin
    bus.dc_valid    = aresetn & any_valid & ~blocked & ~flush;
    bus.dc_op       = 1'b0;
    bus.dc_addr     = '0;
    bus.dc_uncached = 1'b0;
    bus.dc_awstrb   = '0;
    bus.dc_wdata    = '0;
    if (any_valid) begin
      if (sel == LANE0) begin
        bus.dc_op       = bus.req0_op;
        bus.dc_addr     = bus.req0_addr;
        bus.dc_uncached = bus.req0_uncached;
        bus.dc_awstrb   = bus.req0_wstrb;
        bus.dc_wdata    = bus.req0_wdata;
      end else begin
        bus.dc_op       = bus.req1_op;
        bus.dc_addr     = bus.req1_addr;
        bus.dc_uncached = bus.req1_uncached;
        bus.dc_awstrb   = bus.req1_wstrb;
        bus.dc_wdata    = bus.req1_wdata;
      end
    end
    bus.req0_ready = accept & (sel == LANE0);
    bus.req1_ready = accept & (sel == LANE1);
  end

  // Response routing to the lane recorded at the FIFO head.
  always_comb begin
    bus.resp0_valid = resp_ok & (head.lane == LANE0);
    bus.resp1_valid = resp_ok & (head.lane == LANE1);
    bus.resp0_rdata = bus.resp0_valid ? bus.dc_rdata : '0;
    bus.resp1_rdata = bus.resp1_valid ? bus.dc_rdata : '0;
  end

  dcache_arb_tag_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_tag_fifo (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .push       (push),
    .push_data  ('{lane: sel, drop: 1'b0}),
    .pop        (pop),
    .flush_mark (flush),
    .head       (head),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  // Sticky protocol error: read data arrived with nothing outstanding.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                           proto_err <= 1'b0;
    else if (bus.dc_rvalid && count == '0) proto_err <= 1'b1;
  end

`ifdef DCACHE_ARB_PERF_EN
  // Cycles where both lanes compete, and cycles where a read is held off by a full FIFO.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      perf_conflict <= '0;
      perf_blocked  <= '0;
    end else begin
      if (bus.req0_valid && bus.req1_valid) perf_conflict <= perf_conflict + 32'd1;
      if (any_valid && blocked)             perf_blocked  <= perf_blocked + 32'd1;
    end
  end
`endif

endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
- Shares the single dcache load/store port between the two EXM-stage lanes of the dual-issue core.
- Lane 0 is always the older instruction of an issue pair, so it has fixed priority.
- Read responses are returned to the lane that issued them, in order, using a small tag FIFO.
- Flush drops responses for reads that are already in flight.
- Sits between EXM_stage1/EXM_stage2 and the dcache, replacing the combinational request mux.

Parameters:
- OUTSTANDING, 2, maximum number of accepted reads awaiting rvalid (power of two, 1..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush (OR of the EXM flush outputs).
- reqN_valid  in  1  lane N request, N=0,1 (same for all reqN/respN ports).
- reqN_op  in  1  0 = read, 1 = write.
- reqN_addr  in  ADDR_W  address.
- reqN_uncached  in  1  uncached access.
- reqN_wstrb  in  DATA_W/8  write strobe.
- reqN_wdata  in  DATA_W  write data.
- reqN_ready  out  1  request accepted this cycle.
- respN_valid  out  1  read data for lane N.
- respN_rdata  out  DATA_W  read data.
- dc_valid  out  1  dcache request valid.
- dc_ready  in  1  dcache accepts the request.
- dc_op, dc_addr, dc_uncached, dc_awstrb, dc_wdata  out  1/ADDR_W/1/DATA_W/8/DATA_W  forwarded request fields.
- dc_rvalid  in  1  dcache read data valid.
- dc_rdata  in  DATA_W  dcache read data.
- proto_err  out  1  sticky flag: dc_rvalid arrived with no outstanding read.

Behaviour:
- Reset (asynchronous, aresetn=0): tag FIFO empty, count=0, proto_err=0. All valid and ready outputs are 0 while in reset.
- Grant is combinational, fixed priority:
  - sel = 0 if req0_valid, else 1.
  - Candidate request = reqsel.
- Read blocking: blocked = (candidate op==0) && (count==OUTSTANDING). A pop in the same cycle gives no bypass.
- dc_valid = (req0_valid | req1_valid) & ~blocked & ~flush.
- dc_* data fields mirror the selected lane; they are 0 when no lane is valid.
- reqsel_ready = dc_valid & dc_ready. The non-selected lane's ready is 0.
  - Lane 1 therefore waits at least one extra cycle when both lanes request.
- Request latency is 0 cycles (combinational pass-through). The issuing lane must hold its request until ready.
- Tag FIFO:
  - On an accepted read, push {lane=sel, drop=0}.
  - Writes push nothing (the dcache gives no write response).
- Response routing:
  - On dc_rvalid with count>0, pop the head entry.
  - If head.drop==0, assert resp[head.lane]_valid with respN_rdata=dc_rdata in the same cycle (0 latency).
  - If head.drop==1, discard silently.
  - The other lane's resp_valid is 0.
- dc_rvalid with count==0: ignored; proto_err is set to 1 and stays 1 until reset.
- Flush:
  - Sets drop=1 on every valid FIFO entry.
  - Forces dc_valid=0 that cycle.
  - A dc_rvalid in the same cycle as flush is still popped, but is dropped (resp valid = 0).
  - count is not cleared; in-flight reads drain normally.
- Simultaneous push and pop: count is unchanged; pointers wrap modulo OUTSTANDING.
- Two states per lane are implicit (idle/waiting). No explicit FSM beyond the FIFO count.

Optional Feature:
- Macro: DCACHE_ARB_PERF_EN.
- Defined: adds outputs perf_conflict (32-bit) and perf_blocked (32-bit), both reset to 0 and wrapping at 2^32.
  - perf_conflict increments on each cycle with req0_valid & req1_valid.
  - perf_blocked increments on each cycle with a valid candidate and blocked=1.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package dcache_arb_pkg:
  - lane_e enum (LANE0, LANE1).
  - tag_entry_t struct {lane_e lane; logic drop}.
  - OP_READ/OP_WRITE constants.
- One sub-module: dcache_arb_tag_fifo (parameterised depth, push/pop/flush-mark, count, full/empty).

Test Plan:
- Reset mid-operation: 2 reads outstanding, assert aresetn=0 -> count=0 and all outputs 0 immediately; later rvalid sets proto_err=1.
- Both lanes read (lane0 addr 0x100, lane1 addr 0x200), dc_ready=1 -> cycle 1: dc_addr=0x100, req0_ready=1, req1_ready=0; cycle 2: dc_addr=0x200. rvalid data 0xAAAA then 0xBBBB -> resp0=0xAAAA, then resp1=0xBBBB.
- OUTSTANDING=2: two lane0 reads accepted without rvalid, a third read is presented -> dc_valid=0; next cycle rvalid -> pop; following cycle third read accepted.
- Lane1 write 0x300, wstrb=0xF, wdata=0xDEADBEEF, concurrent with an outstanding lane0 read -> write forwarded, count unchanged; rvalid routes to resp0 only.
- Flush with 2 reads outstanding and a new req0 valid -> dc_valid=0 that cycle; the next two rvalids produce no resp_valid; count returns to 0.
- rvalid with an empty FIFO -> no resp_valid, proto_err=1 and sticky.
